// File: rtl/wbm_cmd_master_pkg.sv
// Shared definitions for the Wishbone command masters: FSM state
// encodings and the default abort timeout.
package wbm_cmd_master_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   localparam int unsigned DEFAULT_TIMEOUT = 32'd255;

endpackage

// File: rtl/wb_timeout.sv
// Saturating cycle counter used to abort bus transactions whose slave
// never acknowledges. The count is cleared on clr_i, advances on en_i,
// sticks at MAX, and expired_o flags that it has reached MAX.
module wb_timeout #(
   parameter int unsigned MAX   = 32'd255,
   parameter int unsigned CNT_W = $clog2(MAX + 32'd1)
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear wins, otherwise increment until saturated.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (en_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/wbm_cmd_master.sv
// Wishbone B4 pipelined master: one command in, one single-beat bus
// transaction out, one response back. Only one transaction is in flight.
// All outputs come from flops or from a decode of the state register, so
// no input reaches an output combinationally.
module wbm_cmd_master
   import wbm_cmd_master_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32'd16,
   parameter int unsigned DATA_W  = 32'd32,
   parameter int unsigned SEL_W   = DATA_W / 32'd8,
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_ni,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_we_i,
   input  logic [SEL_W-1:0]  cmd_sel_i,
   input  logic [ADDR_W-1:0] cmd_adr_i,
   input  logic [DATA_W-1:0] cmd_dat_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] rsp_dat_o,
   output logic              rsp_err_o,
   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   input  logic              wb_stall_i,
   input  logic              wb_ack_i,
   output logic              wb_we_o,
   output logic [SEL_W-1:0]  wb_sel_o,
   output logic [ADDR_W-1:0] wb_adr_o,
   output logic [DATA_W-1:0] wb_dat_o,
   input  logic [DATA_W-1:0] wb_dat_i
);

   logic [1:0]        state_q,   state_d;
   logic              we_q,      we_d;
   logic [SEL_W-1:0]  sel_q,     sel_d;
   logic [ADDR_W-1:0] adr_q,     adr_d;
   logic [DATA_W-1:0] dat_q,     dat_d;
   logic [DATA_W-1:0] rsp_dat_q, rsp_dat_d;
   logic              rsp_err_q, rsp_err_d;

   logic              tmo_clr_s;
   logic              tmo_en_s;
   logic              tmo_expired_s;

   wb_timeout #(
      .MAX (TIMEOUT)
   ) u_timeout (
      .clk_i     (wb_clk_i),
      .rst_ni    (wb_rst_ni),
      .clr_i     (tmo_clr_s),
      .en_i      (tmo_en_s),
      .expired_o (tmo_expired_s)
   );

   // Transaction FSM: next state, command latch and response capture.
   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      sel_d     = sel_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      rsp_dat_d = rsp_dat_q;
      rsp_err_d = rsp_err_q;
      tmo_clr_s = 1'b0;
      tmo_en_s  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid_i) begin
               we_d      = cmd_we_i;
               sel_d     = cmd_sel_i;
               adr_d     = cmd_adr_i;
               dat_d     = cmd_dat_i;
               tmo_clr_s = 1'b1;
               state_d   = S_REQ;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REQ: begin
            tmo_en_s = 1'b1;
            // An ack here is spurious, so expiry alone decides the abort.
            if (tmo_expired_s) begin
               rsp_dat_d = {DATA_W{1'b0}};
               rsp_err_d = 1'b1;
               state_d   = S_RESP;
            end else if (!wb_stall_i) begin
               state_d = S_WAIT;
            end else begin
               state_d = S_REQ;
            end
         end
         S_WAIT: begin
            tmo_en_s = 1'b1;
            // A late ack arriving on the expiry cycle still completes normally.
            if (wb_ack_i) begin
               rsp_dat_d = we_q ? {DATA_W{1'b0}} : wb_dat_i;
               rsp_err_d = 1'b0;
               state_d   = S_RESP;
            end else if (tmo_expired_s) begin
               rsp_dat_d = {DATA_W{1'b0}};
               rsp_err_d = 1'b1;
               state_d   = S_RESP;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_RESP: begin
            if (rsp_ready_i) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RESP;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, bus request and response registers.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q   <= S_IDLE;
         we_q      <= 1'b0;
         sel_q     <= {SEL_W{1'b0}};
         adr_q     <= {ADDR_W{1'b0}};
         dat_q     <= {DATA_W{1'b0}};
         rsp_dat_q <= {DATA_W{1'b0}};
         rsp_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         we_q      <= we_d;
         sel_q     <= sel_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
         rsp_dat_q <= rsp_dat_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   assign cmd_ready_o = (state_q == S_IDLE);
   assign wb_cyc_o    = (state_q == S_REQ) || (state_q == S_WAIT);
   assign wb_stb_o    = (state_q == S_REQ);
   assign rsp_valid_o = (state_q == S_RESP);
   assign rsp_dat_o   = rsp_dat_q;
   assign rsp_err_o   = rsp_err_q;
   assign wb_we_o     = we_q;
   assign wb_sel_o    = sel_q;
   assign wb_adr_o    = adr_q;
   assign wb_dat_o    = dat_q;

endmodule

// File: tb/tb_wbm_cmd_master.sv
// Directed bench for wbm_cmd_master (TIMEOUT=8): a table of single
// transactions driven through a small scripted slave, plus hand-written
// sequences for backpressure/spurious acks and a mid-transaction reset.
module tb_wbm_cmd_master;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_we;
   logic [3:0]  cmd_sel;
   logic [15:0] cmd_adr;
   logic [31:0] cmd_dat;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_dat;
   logic        rsp_err;
   logic        wb_cyc;
   logic        wb_stb;
   logic        wb_stall;
   logic        wb_ack;
   logic        wb_we;
   logic [3:0]  wb_sel;
   logic [15:0] wb_adr;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i;

   int errors = 0;
   int checks = 0;

   wbm_cmd_master #(
      .ADDR_W  (16),
      .DATA_W  (32),
      .TIMEOUT (8)
   ) dut (
      .wb_clk_i    (clk),
      .wb_rst_ni   (rst_n),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_we_i    (cmd_we),
      .cmd_sel_i   (cmd_sel),
      .cmd_adr_i   (cmd_adr),
      .cmd_dat_i   (cmd_dat),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_dat_o   (rsp_dat),
      .rsp_err_o   (rsp_err),
      .wb_cyc_o    (wb_cyc),
      .wb_stb_o    (wb_stb),
      .wb_stall_i  (wb_stall),
      .wb_ack_i    (wb_ack),
      .wb_we_o     (wb_we),
      .wb_sel_o    (wb_sel),
      .wb_adr_o    (wb_adr),
      .wb_dat_o    (wb_dat_o),
      .wb_dat_i    (wb_dat_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One transaction: stall = REQ cycles with stall high, ackd = WAIT cycles
   // before the ack (-1 = never), lat = cycle of rsp_valid (cycle 0 = handshake).
   typedef struct {
      logic        we;
      logic [3:0]  sel;
      logic [15:0] adr;
      logic [31:0] dat;
      int          stall;
      int          ackd;
      logic [31:0] rdata;
      logic [31:0] exp_dat;
      logic        exp_err;
      int          exp_lat;
      int          exp_stb;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input int idx);
      vec_t v;
      int   stb_n;
      int   wait_n;
      int   lat;
      bit   got;
      bit   stable_ok;
      v = tbl[idx];
      stb_n = 0;
      wait_n = 0;
      lat = 0;
      got = 1'b0;
      stable_ok = 1'b1;
      chk($sformatf("v%0d_idle_ready", idx), {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_we    = v.we;
      cmd_sel   = v.sel;
      cmd_adr   = v.adr;
      cmd_dat   = v.dat;
      step();
      // Scramble the command inputs to prove the bus side was latched.
      cmd_valid = 1'b0;
      cmd_we    = ~v.we;
      cmd_sel   = ~v.sel;
      cmd_adr   = ~v.adr;
      cmd_dat   = ~v.dat;
      for (int c = 1; c <= 40 && !got; c++) begin
         wb_ack   = 1'b0;
         wb_stall = 1'b0;
         wb_dat_i = 32'h0000_0000;
         if (rsp_valid) begin
            got = 1'b1;
            lat = c;
         end else begin
            if (wb_cyc) begin
               if (wb_we !== v.we || wb_sel !== v.sel || wb_adr !== v.adr || wb_dat_o !== v.dat)
                  stable_ok = 1'b0;
            end
            if (wb_stb) begin
               stb_n++;
               wb_stall = (stb_n <= v.stall);
            end else if (wb_cyc) begin
               wait_n++;
               if (v.ackd >= 0 && wait_n == v.ackd + 1) begin
                  wb_ack   = 1'b1;
                  wb_dat_i = v.rdata;
               end
            end
            step();
         end
      end
      wb_ack   = 1'b0;
      wb_stall = 1'b0;
      chk($sformatf("v%0d_rsp_seen", idx), {31'd0, got}, 32'd1);
      chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
      chk($sformatf("v%0d_stb_cycles", idx), stb_n, v.exp_stb);
      chk($sformatf("v%0d_bus_stable", idx), {31'd0, stable_ok}, 32'd1);
      chk($sformatf("v%0d_rsp_dat", idx), rsp_dat, v.exp_dat);
      chk($sformatf("v%0d_rsp_err", idx), {31'd0, rsp_err}, {31'd0, v.exp_err});
      chk($sformatf("v%0d_resp_bus", idx), {29'd0, wb_cyc, wb_stb, cmd_ready}, 32'd0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk($sformatf("v%0d_after_hs", idx), {30'd0, rsp_valid, cmd_ready}, 32'd1);
      chk($sformatf("v%0d_adr_held", idx), {16'd0, wb_adr}, {16'd0, v.adr});
   endtask

   initial begin : main
      bit ok;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_we    = 1'b0;
      cmd_sel   = 4'h0;
      cmd_adr   = 16'h0000;
      cmd_dat   = 32'h0000_0000;
      rsp_ready = 1'b0;
      wb_stall  = 1'b0;
      wb_ack    = 1'b0;
      wb_dat_i  = 32'h0000_0000;

      //          we    sel   adr       dat            stall ackd rdata          exp_dat        err  lat stb
      tbl[0] = '{1'b0, 4'hF, 16'h0010, 32'h0000_0000, 0,    0,   32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3, 1};
      tbl[1] = '{1'b1, 4'hF, 16'h0020, 32'h1234_5678, 3,    0,   32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 6, 4};
      tbl[2] = '{1'b0, 4'h3, 16'hFFFF, 32'h0000_0000, 1,    2,   32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0, 6, 2};
      tbl[3] = '{1'b0, 4'hF, 16'h1234, 32'h0000_0000, 0,   -1,   32'hCAFE_F00D, 32'h0000_0000, 1'b1, 10, 1};
      tbl[4] = '{1'b0, 4'hF, 16'h2222, 32'h0000_0000, 20,  -1,   32'hCAFE_F00D, 32'h0000_0000, 1'b1, 10, 9};
      tbl[5] = '{1'b0, 4'hC, 16'h3333, 32'h0000_0000, 0,    7,   32'h0BAD_C0DE, 32'h0BAD_C0DE, 1'b0, 10, 1};
      tbl[6] = '{1'b1, 4'h1, 16'h4444, 32'h8765_4321, 2,    5,   32'h5555_AAAA, 32'h0000_0000, 1'b0, 10, 3};
      tbl[7] = '{1'b0, 4'hF, 16'h5555, 32'h0000_0000, 0,    6,   32'h7777_8888, 32'h7777_8888, 1'b0, 9, 1};

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ctrl", {27'd0, cmd_ready, rsp_valid, rsp_err, wb_cyc, wb_stb}, 32'h10);
      chk("rst_bus", {11'd0, wb_we, wb_sel, wb_adr}, 32'd0);
      chk("rst_dat", wb_dat_o | rsp_dat, 32'd0);
      #2 rst_n = 1'b1;
      step();

      for (int i = 0; i < 8; i++) begin
         run_vec(i);
      end

      // Spurious acks in REQ, RESP and IDLE, with response backpressure.
      cmd_valid = 1'b1;
      cmd_we    = 1'b0;
      cmd_sel   = 4'hF;
      cmd_adr   = 16'h0040;
      cmd_dat   = 32'h0000_0000;
      step();
      cmd_valid = 1'b0;
      wb_stall  = 1'b1;
      wb_ack    = 1'b1;
      wb_dat_i  = 32'h9999_9999;
      step();
      chk("bp_req_ack_ignored", {29'd0, wb_cyc, wb_stb, rsp_valid}, 32'h6);
      wb_stall = 1'b0;
      wb_ack   = 1'b0;
      step();
      chk("bp_wait", {29'd0, wb_cyc, wb_stb, rsp_valid}, 32'h4);
      wb_ack   = 1'b1;
      wb_dat_i = 32'h1111_2222;
      step();
      wb_ack = 1'b0;
      chk("bp_rsp_dat", rsp_dat, 32'h1111_2222);
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cmd_valid = 1'b1;
         cmd_adr   = 16'h0080;
         rsp_ready = 1'b0;
         wb_ack    = (i % 2 == 0);
         wb_dat_i  = 32'h3333_4444;
         step();
         if (!(rsp_valid === 1'b1 && rsp_dat === 32'h1111_2222 && rsp_err === 1'b0 &&
               cmd_ready === 1'b0 && wb_cyc === 1'b0))
            ok = 1'b0;
      end
      chk("bp_hold", {31'd0, ok}, 32'd1);
      cmd_valid = 1'b0;
      wb_ack    = 1'b0;
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("bp_handshake", {29'd0, rsp_valid, cmd_ready, wb_cyc}, 32'h2);
      ok = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wb_ack   = 1'b1;
         wb_dat_i = 32'h5555_6666;
         step();
         if (rsp_valid !== 1'b0 || wb_cyc !== 1'b0 || cmd_ready !== 1'b1) ok = 1'b0;
      end
      wb_ack = 1'b0;
      chk("idle_ack_ignored", {31'd0, ok}, 32'd1);
      chk("idle_rsp_held", rsp_dat, 32'h1111_2222);

      // Reset asserted while waiting for the ack.
      cmd_valid = 1'b1;
      cmd_we    = 1'b0;
      cmd_adr   = 16'h0050;
      step();
      cmd_valid = 1'b0;
      step();
      chk("mr_wait", {30'd0, wb_cyc, wb_stb}, 32'h2);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_async", {28'd0, wb_cyc, wb_stb, rsp_valid, cmd_ready}, 32'h1);
      @(posedge clk);
      #2 rst_n = 1'b1;
      step();
      chk("mr_after", {28'd0, cmd_ready, rsp_valid, wb_cyc, rsp_err}, 32'h8);
      chk("mr_rsp_dat", rsp_dat, 32'd0);
      step();
      chk("mr_stays_idle", {29'd0, cmd_ready, rsp_valid, wb_cyc}, 32'h4);

      run_vec(0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
